// File: rtl/secuenciador_pkg.sv
// Shared definitions for the writeback sequencer: FSM states, ALU opcodes and
// the R-type funct codes the ALU understands.
package secuenciador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXEC   = 3'd1,
        ST_MEM_WR = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASS  = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_funct.sv
// Combinational ALU: alu_op selects add/sub/pass directly, or defers to the
// R-type funct field. Unknown funct codes yield zero and raise err.
module alu_funct
    import secuenciador_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    alu_op,
    input  logic [5:0]    funct,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_FUNCT: begin
                case (funct)
                    FN_ADD:  result = a + b;
                    FN_SUB:  result = a - b;
                    FN_AND:  result = a & b;
                    FN_OR:   result = a | b;
                    FN_SLT:  result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
                    default: err = 1'b1;
                endcase
            end
            ALU_PASS: result = a;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/secuenciador_wb.sv
// Sequencer for one decoded instruction bundle: execute, optional memory
// write, optional memory read, optional register writeback, then back to idle.
module secuenciador_wb
    import secuenciador_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mem_to_reg,
    input  logic          mem_to_write,
    input  logic          reg_write,
    input  logic [1:0]    alu_op,
    input  logic [5:0]    funct,
    input  logic [DW-1:0] rs_val,
    input  logic [DW-1:0] rt_val,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          funct_err
);

    state_t        state_q, state_d;
    logic          mem_to_reg_q, mem_to_write_q, reg_write_q;
    logic [1:0]    alu_op_q;
    logic [5:0]    funct_q;
    logic [DW-1:0] rs_q, rt_q, alu_q, rdata_q;
    logic [AW-1:0] rd_q;
    logic          err_q;
    logic [DW-1:0] alu_result;
    logic          alu_err;

    alu_funct #(.DW(DW)) u_alu (
        .alu_op (alu_op_q),
        .funct  (funct_q),
        .a      (rs_q),
        .b      (rt_q),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (mem_to_write_q)   state_d = ST_MEM_WR;
                else if (mem_to_reg_q) state_d = ST_MEM_RD;
                else if (reg_write_q)  state_d = ST_WB;
                else                   state_d = ST_IDLE;
            end
            ST_MEM_WR: begin
                if (mem_ack) begin
                    if (mem_to_reg_q)     state_d = ST_MEM_RD;
                    else if (reg_write_q) state_d = ST_WB;
                    else                  state_d = ST_IDLE;
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) state_d = reg_write_q ? ST_WB : ST_IDLE;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Holding registers: bundle captured only on handshake, ALU result in EXEC,
    // read data on the acknowledging edge of the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_to_reg_q   <= 1'b0;
            mem_to_write_q <= 1'b0;
            reg_write_q    <= 1'b0;
            alu_op_q       <= '0;
            funct_q        <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            alu_q          <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                mem_to_reg_q   <= mem_to_reg;
                mem_to_write_q <= mem_to_write;
                reg_write_q    <= reg_write;
                alu_op_q       <= alu_op;
                funct_q        <= funct;
                rs_q           <= rs_val;
                rt_q           <= rt_val;
                rd_q           <= rd_addr;
            end
            if (state_q == ST_EXEC) begin
                alu_q <= alu_result;
                if (alu_err) err_q <= 1'b1;
            end
            if (state_q == ST_MEM_RD && mem_ack) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign mem_we    = (state_q == ST_MEM_WR);
    assign mem_re    = (state_q == ST_MEM_RD);
    assign mem_addr  = alu_q;
    assign mem_wdata = rt_q;
    assign wb_en     = (state_q == ST_WB) && (rd_q != '0);
    assign wb_addr   = rd_q;
    assign wb_data   = mem_to_reg_q ? rdata_q : alu_q;
    assign funct_err = err_q;

endmodule
